// File: rtl/ecc_pointmul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elliptic_curve_structs (package)
// Description : Shared types and constants for the ECDSA block schedulers.
//               Holds the operand width and the point-multiplication
//               scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package elliptic_curve_structs;

    // Width of scalars and affine coordinates on the supported curves
    localparam int ECC_W = 256;

    // Point-multiplication scheduler states, explicitly encoded
    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE   = 2'd0;
    localparam sched_state_t ST_LAUNCH = 2'd1;
    localparam sched_state_t ST_RUN    = 2'd2;
    localparam sched_state_t ST_RESP   = 2'd3;

endpackage : elliptic_curve_structs
`default_nettype wire

// File: rtl/ecc_pointmul_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches upward from
//               ptr+1 (modulo N) and grants the first asserted request.
//               Reused by the point-multiply, modInv and modmult schedulers.
// Ports       : req       - request vector, one bit per requester
//               ptr       - index of the most recently granted requester
//               grant     - one-hot grant (all zero when req is zero)
//               grant_idx - binary index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int c_idx_w = $clog2(N);

    // One extra bit so ptr+k (at most 2N-1) cannot wrap before the modulo
    logic [c_idx_w:0] w_pos;
    logic             w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = {1'b0, ptr} + (c_idx_w + 1)'(k);
            if (w_pos >= (c_idx_w + 1)'(N)) begin
                w_pos = w_pos - (c_idx_w + 1)'(N);
            end
            if (!w_found && req[w_pos[c_idx_w-1:0]]) begin
                w_found                      = 1'b1;
                grant[w_pos[c_idx_w-1:0]]    = 1'b1;
                grant_idx                    = w_pos[c_idx_w-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ecc_pointmul_sched.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pointmul_sched
// Description : Round-robin scheduler sharing one scalar point multiplier
//               (gen_point) between NUM_REQ requesters. Latches operands on
//               accept, holds the engine in reset for LAUNCH_CYCLES, runs it
//               until Done or timeout, and returns the result to the owner.
// Ports       : clk, rst_n                      - clock, sync active-low reset
//               req_valid/req_ready             - per-requester accept handshake
//               req_scalar/req_px/req_py        - packed operands, 256 b each
//               rsp_valid/rsp_ready             - per-requester response handshake
//               rsp_x/rsp_y/rsp_err             - shared result and error flag
//               eng_reset/eng_scalar/eng_px/py  - engine controls and operands
//               eng_done/eng_x/eng_y            - engine completion and result
//               busy                            - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_pointmul_sched
    import elliptic_curve_structs::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int LAUNCH_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ECC_W-1:0] req_scalar,
    input  logic [NUM_REQ*ECC_W-1:0] req_px,
    input  logic [NUM_REQ*ECC_W-1:0] req_py,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [ECC_W-1:0]         rsp_x,
    output logic [ECC_W-1:0]         rsp_y,
    output logic                     rsp_err,
    output logic                     eng_reset,
    output logic [ECC_W-1:0]         eng_scalar,
    output logic [ECC_W-1:0]         eng_px,
    output logic [ECC_W-1:0]         eng_py,
    input  logic                     eng_done,
    input  logic [ECC_W-1:0]         eng_x,
    input  logic [ECC_W-1:0]         eng_y,
    output logic                     busy
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int c_idx_w = $clog2(NUM_REQ);

    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_launch_last  = c_cnt_w'(LAUNCH_CYCLES - 1);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_idx_w-1:0]   r_owner;
    logic [ECC_W-1:0]     r_eng_scalar;
    logic [ECC_W-1:0]     r_eng_px;
    logic [ECC_W-1:0]     r_eng_py;
    logic [ECC_W-1:0]     r_rsp_x;
    logic [ECC_W-1:0]     r_rsp_y;
    logic                 r_rsp_err;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic [ECC_W-1:0]     w_sel_scalar;
    logic [ECC_W-1:0]     w_sel_px;
    logic [ECC_W-1:0]     w_sel_py;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_timeout;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Operand mux driven by the one-hot grant
    always_comb begin
        w_sel_scalar = '0;
        w_sel_px     = '0;
        w_sel_py     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_scalar = req_scalar[i*ECC_W +: ECC_W];
                w_sel_px     = req_px[i*ECC_W +: ECC_W];
                w_sel_py     = req_py[i*ECC_W +: ECC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and all FSM-derived outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        eng_reset   = 1'b1;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                // Gated by rst_n so no accept pulse is shown while held in reset
                if (rst_n && (|req_valid)) begin
                    w_accept    = 1'b1;
                    req_ready   = w_grant;
                    w_state_nxt = (w_sel_scalar == '0) ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // eng_done deliberately ignored: a stale Done may linger
                if (r_cnt == c_launch_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                eng_reset = 1'b0;
                // Done takes precedence over a coincident timeout
                if (eng_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == c_timeout_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_rr_ptr     <= c_idx_w'(NUM_REQ - 1);
            r_owner      <= '0;
            r_eng_scalar <= '0;
            r_eng_px     <= '0;
            r_eng_py     <= '0;
            r_rsp_x      <= '0;
            r_rsp_y      <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_eng_scalar <= w_sel_scalar;
                r_eng_px     <= w_sel_px;
                r_eng_py     <= w_sel_py;
                r_owner      <= w_grant_idx;
                r_rr_ptr     <= w_grant_idx;
                if (w_sel_scalar == '0) begin
                    r_rsp_x   <= '0;
                    r_rsp_y   <= '0;
                    r_rsp_err <= 1'b1;
                end
            end
            if (w_done) begin
                r_rsp_x   <= eng_x;
                r_rsp_y   <= eng_y;
                r_rsp_err <= 1'b0;
            end
            if (w_timeout) begin
                r_rsp_x   <= '0;
                r_rsp_y   <= '0;
                r_rsp_err <= 1'b1;
            end
            // Counter restarts on every state change and counts the
            // LAUNCH hold and the RUN duration
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_LAUNCH) || (r_state == ST_RUN)) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign rsp_x      = r_rsp_x;
    assign rsp_y      = r_rsp_y;
    assign rsp_err    = r_rsp_err;
    assign eng_scalar = r_eng_scalar;
    assign eng_px     = r_eng_px;
    assign eng_py     = r_eng_py;

endmodule : ecc_pointmul_sched
`default_nettype wire

// File: doc/ecc_pointmul_sched.md
Name: ecc_pointmul_sched

Overview:
- Round-robin scheduler that shares the single scalar-point-multiplication engine (gen_point) between NUM_REQ requesters, such as the key-generation and signing paths.
- Accepts requests with a valid/ready handshake and latches the operands.
- Sequences the engine: holds its active-high Reset, launches the operation, waits for Done, and guards it with a timeout.
- Returns the result to the owning requester.
- Sits between the requesters and the engine inside ecdsa_block. Curve parameters stay in the config registers.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 1048576, maximum number of RUN cycles before the operation is aborted
LAUNCH_CYCLES, 2, number of cycles eng_reset is held high with operands stable before the engine runs

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_scalar  in  NUM_REQ*256  scalars, requester i at bits [256*i+:256]
req_px  in  NUM_REQ*256  base point x values, same packing
req_py  in  NUM_REQ*256  base point y values, same packing
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_x  out  256  result x, shared by all requesters
rsp_y  out  256  result y, shared by all requesters
rsp_err  out  1  error flag, qualified by rsp_valid (zero scalar or timeout)
eng_reset  out  1  to engine Reset (active high)
eng_scalar  out  256  to engine privKey
eng_px  out  256  to engine in_point_x
eng_py  out  256  to engine in_point_y
eng_done  in  1  from engine Done
eng_x  in  256  from engine out_point_x
eng_y  in  256  from engine out_point_y
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, the block enters IDLE. Reset values:
  - req_ready=0, rsp_valid=0, rsp_err=0
  - rsp_x=rsp_y=0
  - eng_reset=1; eng_scalar, eng_px, eng_py=0
  - busy=0
  - rr_ptr=NUM_REQ-1, so requester 0 has priority first.
- eng_reset is 1 in every state except RUN. The engine is therefore parked in reset whenever idle.
- FSM states: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - If any req_valid bit is set, grant g = the first set bit searching upward from rr_ptr+1 modulo NUM_REQ.
  - req_ready[g]=1 combinationally for exactly that cycle.
  - On that edge, latch requester g's scalar, px and py into eng_* (held until the next grant); set owner=g and rr_ptr=g.
  - If the latched scalar is 0, go to RESP with rsp_err=1 and rsp_x=rsp_y=0. The engine is not used.
  - Otherwise go to LAUNCH with cnt=0.
- LAUNCH:
  - eng_reset=1 for LAUNCH_CYCLES cycles. eng_done is ignored, because a stale Done is possible.
  - Then go to RUN with cnt=0.
- RUN:
  - eng_reset=0; cnt increments every cycle.
  - eng_done=1: capture eng_x and eng_y into rsp_x/rsp_y, set rsp_err=0, go to RESP.
  - cnt==TIMEOUT_CYCLES-1 without Done: set rsp_err=1, rsp_x=rsp_y=0, go to RESP.
  - If Done and timeout occur in the same cycle, Done wins.
- RESP:
  - rsp_valid[owner]=1, with rsp_x, rsp_y and rsp_err stable. eng_reset=1.
  - Leave to IDLE on the edge where rsp_ready[owner]=1.
  - rsp_ready bits of other requesters are ignored.
  - No new grant is issued in the RESP exit cycle; arbitration resumes in IDLE on the next cycle.
- Latency:
  - Nonzero scalar: accept edge, then LAUNCH_CYCLES, then the engine cycles until Done, then 1 cycle to RESP.
  - Zero scalar: rsp_valid rises 1 cycle after the accept edge.
- Requester rules:
  - req_valid and operands must stay stable until req_ready.
  - A requester may hold req_valid high while its own response is pending. It is not regranted until after RESP.
- Only one operation is ever in flight. There is no queue: pending requesters simply wait on valid.
- Reset mid-operation (any state) aborts the operation. No response is produced and eng_reset returns to 1 on that edge.
- Width rules: cnt is $clog2(TIMEOUT_CYCLES)+1 bits; rr_ptr and owner are $clog2(NUM_REQ) bits.

Decomposition:
- Shared package elliptic_curve_structs: add sched_state_t (IDLE, LAUNCH, RUN, RESP) and the constant ECC_W=256.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; outputs grant one-hot and grant_idx. Purely combinational and reusable by the later modInv and modmult schedulers.

Test Plan:
- Single request, scalar=1, P=(x=5, y=7); engine model asserts Done after 10 RUN cycles returning (5,7) -> req_ready[0] pulses once; eng_reset high exactly 2 cycles, then low; rsp_valid[0] after RUN cycle 10 with rsp_x=5, rsp_y=7, rsp_err=0; eng_reset back to 1.
- Requester 0 and 1 both valid continuously from reset, with rsp_ready tied high -> grants go 0,1,0,1; each rsp_valid appears only on the owner's bit; no grant while busy=1.
- Scalar=0 from requester 1 -> rsp_valid[1] one cycle after accept, rsp_err=1, rsp_x=rsp_y=0; eng_reset never drops to 0.
- TIMEOUT_CYCLES=16, engine never asserts Done -> after exactly 16 RUN cycles: RESP with rsp_err=1 and zero outputs; next request is processed normally.
- rsp_ready held low for 20 cycles in RESP -> rsp_valid and data are stable throughout; req_valid[1] is not granted until the edge after rsp_ready[0] rises.
- rst_n=0 for one edge during RUN -> next cycle: all outputs at reset values, eng_reset=1, no rsp_valid; stale eng_done pulse during LAUNCH is ignored.
